// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: instruction-memory, redirect and decode signals of the fetch stage
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_ready, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
    );
    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_ready, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: RV32I fetch stage with in-order word buffer and redirect flush
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input logic clk,
    input logic rst,
    instr_fetch_unit_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state;
    logic [31:0]      fetch_pc;
    logic [31:0]      pc_q   [DEPTH];
    logic [31:0]      word_q [DEPTH];
    logic [DEPTH-1:0] filled;
    logic [AW-1:0]    head, tail, fill_ptr;
    logic [CW-1:0]    alloc_cnt, pend_cnt, drop_cnt;
    logic             issue, alloc, fill, drop, pop, head_valid;

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        issue      = state == RUN && (int'(alloc_cnt) + int'(drop_cnt) < DEPTH) && !bus.redirect_valid;
        alloc      = issue && bus.imem_ready;
        drop       = bus.imem_rvalid && drop_cnt != '0;
        fill       = bus.imem_rvalid && drop_cnt == '0 && pend_cnt != '0;
        head_valid = alloc_cnt != '0 && filled[head];
        pop        = head_valid && bus.instr_ready;
    end

    assign bus.imem_req    = issue;
    assign bus.imem_addr   = fetch_pc;
    assign bus.instr_valid = head_valid;
    assign bus.instr       = head_valid ? word_q[head] : NOP_INSTR;
    assign bus.instr_pc    = head_valid ? pc_q[head] : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            filled    <= '0;
            head      <= '0;
            tail      <= '0;
            fill_ptr  <= '0;
            alloc_cnt <= '0;
            pend_cnt  <= '0;
            drop_cnt  <= '0;
        end else begin
            state <= RUN;
            if (bus.redirect_valid) begin
                // every unfilled entry still owes a response; one arriving now is already accounted
                drop_cnt  <= drop_cnt + pend_cnt - CW'(bus.imem_rvalid && (drop_cnt != '0 || pend_cnt != '0));
                fetch_pc  <= {bus.redirect_pc[31:2], 2'b00};
                filled    <= '0;
                head      <= '0;
                tail      <= '0;
                fill_ptr  <= '0;
                alloc_cnt <= '0;
                pend_cnt  <= '0;
            end else begin
                if (alloc) begin
                    pc_q[tail]   <= fetch_pc;
                    filled[tail] <= 1'b0;
                    tail         <= inc(tail);
                    fetch_pc     <= fetch_pc + 32'd4;
                end
                if (fill) begin
                    word_q[fill_ptr] <= bus.imem_rdata;
                    filled[fill_ptr] <= 1'b1;
                    fill_ptr         <= inc(fill_ptr);
                end
                if (pop)
                    head <= inc(head);
                if (drop)
                    drop_cnt <= drop_cnt - 1'b1;
                alloc_cnt <= alloc_cnt + CW'(alloc) - CW'(pop);
                pend_cnt  <= pend_cnt + CW'(alloc) - CW'(fill);
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: random-latency memory model plus in-order fetch scoreboard
module tb_instr_fetch_unit;
    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_fetch_unit_if bus();
    instr_fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {logic [31:0] addr; int due;} rq_t;
    rq_t mq[$];
    int n_vec = 0, n_err = 0;
    int cyc_n = 0, last_due = 0, lat_lo = 1, lat_hi = 1;
    logic [31:0] exp_issue = RPC, exp_next = RPC;
    logic s_req, s_valid, s_acc, s_pop, s_rvalid, s_redir;
    logic [31:0] s_addr, s_instr, s_pc, s_exp_addr, s_exp_pc;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // one clock: sample before the edge, advance the model, drive memory response after it
    task automatic tick();
        int due;
        @(negedge clk);
        s_req = bus.imem_req; s_addr = bus.imem_addr; s_valid = bus.instr_valid;
        s_instr = bus.instr; s_pc = bus.instr_pc; s_rvalid = bus.imem_rvalid;
        s_redir = bus.redirect_valid;
        s_acc = s_req && bus.imem_ready;
        s_pop = s_valid && bus.instr_ready && !s_redir;
        s_exp_addr = exp_issue; s_exp_pc = exp_next;
        if (s_redir) begin
            exp_issue = {bus.redirect_pc[31:2], 2'b00};
            exp_next  = exp_issue;
        end else begin
            if (s_acc) exp_issue += 32'd4;
            if (s_pop) exp_next += 32'd4;
        end
        if (s_acc) begin
            due = cyc_n + int'($urandom_range(lat_hi, lat_lo));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq.push_back('{s_addr, due});
        end
        @(posedge clk); #1;
        cyc_n++;
        if (rst) begin
            mq.delete(); last_due = 0; exp_issue = RPC; exp_next = RPC;
        end
        if (mq.size() > 0 && mq[0].due <= cyc_n) begin
            bus.imem_rvalid = 1'b1; bus.imem_rdata = mem(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            bus.imem_rvalid = 1'b0; bus.imem_rdata = $urandom;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.redirect_valid = 1'b0; bus.imem_ready = 1'b0; bus.instr_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_vec++; if (s_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", s_req); end
        n_vec++; if (s_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", s_valid); end
        n_vec++; if (s_instr !== NOP) begin n_err++; $display("FAIL reset_instr: got %h want %h", s_instr, NOP); end
        n_vec++; if (s_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want 0", s_pc); end
        n_vec++; if (s_addr !== RPC) begin n_err++; $display("FAIL reset_addr: got %h want %h", s_addr, RPC); end
        rst = 1'b0;
    endtask

    task automatic test_stream();
        int got = 0;
        do_reset();
        bus.imem_ready = 1'b1; bus.instr_ready = 1'b1; lat_lo = 1; lat_hi = 1;
        for (int t = 0; t < 14; t++) begin
            tick();
            if (t == 0) begin n_vec++; if (s_req !== 1'b0) begin n_err++; $display("FAIL stream_idle_req: got %b want 0", s_req); end end
            if (t == 1) begin n_vec++; if (s_req !== 1'b1 || s_addr !== RPC) begin n_err++; $display("FAIL stream_first_req: got %b/%h want 1/%h", s_req, s_addr, RPC); end end
            if (t == 2) begin n_vec++; if (s_valid !== 1'b0) begin n_err++; $display("FAIL stream_early_valid: got %b want 0", s_valid); end end
            if (t == 3) begin n_vec++; if (s_valid !== 1'b1 || s_pc !== RPC) begin n_err++; $display("FAIL stream_first_valid: got %b/%h want 1/%h", s_valid, s_pc, RPC); end end
            if (s_acc) begin n_vec++; if (s_addr !== s_exp_addr) begin n_err++; $display("FAIL stream_addr: got %h want %h", s_addr, s_exp_addr); end end
            if (s_pop) begin
                got++;
                n_vec++; if (s_pc !== s_exp_pc || s_instr !== mem(s_exp_pc)) begin n_err++; $display("FAIL stream_deliver: got %h/%h want %h/%h", s_pc, s_instr, s_exp_pc, mem(s_exp_pc)); end
            end
        end
        n_vec++; if (got < 4) begin n_err++; $display("FAIL stream_count: got %0d want >=4", got); end
    endtask

    task automatic test_stall();
        int acc = 0;
        logic [31:0] seen[$];
        do_reset();
        bus.imem_ready = 1'b1; bus.instr_ready = 1'b0; lat_lo = 1; lat_hi = 1;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (s_acc) acc++;
        end
        n_vec++; if (acc != DEPTH) begin n_err++; $display("FAIL stall_accepts: got %0d want %0d", acc, DEPTH); end
        n_vec++; if (s_req !== 1'b0) begin n_err++; $display("FAIL stall_req: got %b want 0", s_req); end
        n_vec++; if (s_valid !== 1'b1 || s_pc !== RPC || s_instr !== mem(RPC)) begin n_err++; $display("FAIL stall_hold: got %b/%h/%h want 1/%h/%h", s_valid, s_pc, s_instr, RPC, mem(RPC)); end
        bus.instr_ready = 1'b1;
        for (int t = 0; t < 15; t++) begin
            tick();
            if (s_pop) begin
                seen.push_back(s_pc);
                n_vec++; if (s_pc !== s_exp_pc || s_instr !== mem(s_exp_pc)) begin n_err++; $display("FAIL stall_deliver: got %h/%h want %h/%h", s_pc, s_instr, s_exp_pc, mem(s_exp_pc)); end
            end
        end
        n_vec++;
        if (seen.size() < 3 || seen[0] !== 32'h0 || seen[1] !== 32'h4 || seen[2] !== 32'h8) begin
            n_err++; $display("FAIL stall_order: got %0d pcs first %h want 0,4,8", seen.size(), seen.size() > 0 ? seen[0] : 32'hx);
        end
    endtask

    task automatic test_redirect_inflight();
        bit got_acc = 0, got_pop = 0;
        do_reset();
        bus.imem_ready = 1'b1; bus.instr_ready = 1'b1; lat_lo = 3; lat_hi = 3;
        tick(); tick(); tick();
        n_vec++; if (mq.size() != 2) begin n_err++; $display("FAIL redir_inflight: got %0d want 2", mq.size()); end
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0103;
        tick();
        bus.redirect_valid = 1'b0;
        n_vec++; if (s_req !== 1'b0) begin n_err++; $display("FAIL redir_req_blocked: got %b want 0", s_req); end
        for (int t = 0; t < 20; t++) begin
            tick();
            if (s_acc && !got_acc) begin
                got_acc = 1;
                n_vec++; if (s_addr !== 32'h100) begin n_err++; $display("FAIL redir_first_addr: got %h want 00000100", s_addr); end
            end
            if (s_pop) begin
                if (!got_pop) begin n_vec++; if (s_pc !== 32'h100) begin n_err++; $display("FAIL redir_first_pc: got %h want 00000100", s_pc); end end
                got_pop = 1;
                n_vec++; if (s_pc !== s_exp_pc || s_instr !== mem(s_exp_pc)) begin n_err++; $display("FAIL redir_deliver: got %h/%h want %h/%h", s_pc, s_instr, s_exp_pc, mem(s_exp_pc)); end
            end
        end
        n_vec++; if (!got_acc || !got_pop) begin n_err++; $display("FAIL redir_timeout: got acc=%0d pop=%0d want 1/1", got_acc, got_pop); end
    endtask

    task automatic test_redirect_collide();
        bit got_pop = 0;
        do_reset();
        bus.imem_ready = 1'b1; bus.instr_ready = 1'b1; lat_lo = 1; lat_hi = 1;
        tick(); tick(); tick();
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0200;
        tick();
        bus.redirect_valid = 1'b0;
        n_vec++; if (s_valid !== 1'b1 || s_rvalid !== 1'b1) begin n_err++; $display("FAIL collide_setup: got valid=%b rvalid=%b want 1/1", s_valid, s_rvalid); end
        for (int t = 0; t < 10; t++) begin
            tick();
            if (t == 0) begin n_vec++; if (s_req !== 1'b1 || s_addr !== 32'h200) begin n_err++; $display("FAIL collide_next_req: got %b/%h want 1/00000200", s_req, s_addr); end end
            if (s_pop) begin
                if (!got_pop) begin n_vec++; if (s_pc !== 32'h200) begin n_err++; $display("FAIL collide_first_pc: got %h want 00000200", s_pc); end end
                got_pop = 1;
                n_vec++; if (s_pc !== s_exp_pc || s_instr !== mem(s_exp_pc)) begin n_err++; $display("FAIL collide_deliver: got %h/%h want %h/%h", s_pc, s_instr, s_exp_pc, mem(s_exp_pc)); end
            end
        end
        n_vec++; if (!got_pop) begin n_err++; $display("FAIL collide_timeout: got no delivery want one"); end
    endtask

    task automatic test_wrap_and_reset();
        logic [31:0] accs[$];
        bus.imem_ready = 1'b1; bus.instr_ready = 1'b1; lat_lo = 1; lat_hi = 1;
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC;
        tick();
        bus.redirect_valid = 1'b0;
        for (int t = 0; t < 8; t++) begin
            tick();
            if (s_acc) accs.push_back(s_addr);
            if (s_pop) begin n_vec++; if (s_pc !== s_exp_pc || s_instr !== mem(s_exp_pc)) begin n_err++; $display("FAIL wrap_deliver: got %h/%h want %h/%h", s_pc, s_instr, s_exp_pc, mem(s_exp_pc)); end end
        end
        n_vec++;
        if (accs.size() < 2 || accs[0] !== 32'hFFFF_FFFC || accs[1] !== 32'h0) begin
            n_err++; $display("FAIL wrap_addr: got %0d reqs first %h want FFFFFFFC,00000000", accs.size(), accs.size() > 0 ? accs[0] : 32'hx);
        end
        rst = 1'b1;
        tick(); tick();
        n_vec++; if (s_valid !== 1'b0 || s_req !== 1'b0 || s_instr !== NOP) begin n_err++; $display("FAIL midreset_outputs: got valid=%b req=%b instr=%h want 0/0/%h", s_valid, s_req, s_instr, NOP); end
        rst = 1'b0;
        tick();
        n_vec++; if (s_req !== 1'b0) begin n_err++; $display("FAIL midreset_idle: got %b want 0", s_req); end
        tick();
        n_vec++; if (s_req !== 1'b1 || s_addr !== RPC) begin n_err++; $display("FAIL midreset_restart: got %b/%h want 1/%h", s_req, s_addr, RPC); end
    endtask

    task automatic test_random();
        int deliv = 0;
        bit hold = 0;
        logic [31:0] p_addr = 32'h0;
        do_reset();
        lat_lo = 1; lat_hi = 5;
        for (int c = 0; c < 2000; c++) begin
            bus.imem_ready     = $urandom_range(3) != 0;
            bus.instr_ready    = $urandom_range(1) != 0;
            bus.redirect_valid = $urandom_range(19) == 0;
            bus.redirect_pc    = $urandom_range(3) == 0 ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
            tick();
            n_vec++; if (!s_valid && s_instr !== NOP) begin n_err++; $display("FAIL rand_nop: got %h want %h", s_instr, NOP); end
            if (s_acc) begin n_vec++; if (s_addr !== s_exp_addr) begin n_err++; $display("FAIL rand_addr: got %h want %h", s_addr, s_exp_addr); end end
            if (s_pop) begin
                deliv++;
                n_vec++; if (s_pc !== s_exp_pc || s_instr !== mem(s_exp_pc)) begin n_err++; $display("FAIL rand_deliver: got %h/%h want %h/%h", s_pc, s_instr, s_exp_pc, mem(s_exp_pc)); end
            end
            if (s_redir) begin n_vec++; if (s_req !== 1'b0) begin n_err++; $display("FAIL rand_redir_req: got %b want 0", s_req); end end
            if (hold && !s_redir) begin n_vec++; if (s_req !== 1'b1 || s_addr !== p_addr) begin n_err++; $display("FAIL rand_hold: got %b/%h want 1/%h", s_req, s_addr, p_addr); end end
            hold = s_req && !s_acc; p_addr = s_addr;
            n_vec++; if (mq.size() > DEPTH) begin n_err++; $display("FAIL rand_outstanding: got %0d want <=%0d", mq.size(), DEPTH); end
        end
        n_vec++; if (deliv < 50) begin n_err++; $display("FAIL rand_progress: got %0d want >=50", deliv); end
    endtask

    initial begin
        bus.imem_ready = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
        bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0; bus.instr_ready = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_inflight();
        test_redirect_collide();
        test_wrap_and_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
